superh16_sched_alloc_ctrl: RTL and testbench

- Allocation steering and credit controller sitting between rename and the scheduler banks.
- Tracks free entries per scheduler bank with credit counters and steers each cycle's renamed group into bank slots, rotating the starting bank round-robin.
- Group allocation is all-or-nothing: if the whole group cannot be placed, rename is back-pressured.
- Replaces fixed index-based steering, so a full bank no longer stalls the machine while other banks have room.

---
 rtl/superh16_sched_alloc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_superh16_sched_alloc_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/superh16_sched_alloc_ctrl.sv
// superh16_sched_alloc_ctrl
// Steers each renamed group into scheduler bank slots and keeps a free-entry
// credit counter per bank. The starting bank rotates round-robin. A group is
// placed whole or not at all; if any valid request cannot be placed, rename
// is back-pressured.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   alloc_req          per-request valid from rename (may be sparse)
//   alloc_ready        whole group accepted this cycle (combinational)
//   alloc_bank/slot    destination bank / slot per request (0 when not fired)
//   bank_alloc_valid   per bank-slot write enable, qualified by alloc_ready
//   bank_alloc_src     request index feeding each bank slot
//   bank_release_cnt   entries freed per bank this cycle
//   flush              full scheduler flush; banks empty next cycle
//   bank_credit        registered free-entry count per bank
//   credit_err         sticky credit overflow/underflow flag
//   stall_count        saturating count of back-pressured cycles
module superh16_sched_alloc_ctrl #(
  parameter  int unsigned NUM_BANKS      = 3,
  parameter  int unsigned BANK_ENTRIES   = 64,
  parameter  int unsigned SLOTS_PER_BANK = 4,
  parameter  int unsigned ALLOC_WIDTH    = 12,
  localparam int unsigned BANK_BITS      = $clog2(NUM_BANKS),
  localparam int unsigned SLOT_BITS      = $clog2(SLOTS_PER_BANK),
  localparam int unsigned IDX_BITS       = $clog2(ALLOC_WIDTH),
  localparam int unsigned CRED_BITS      = $clog2(BANK_ENTRIES + 1),
  localparam int unsigned REL_BITS       = SLOT_BITS + 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [ALLOC_WIDTH-1:0]                         alloc_req,
  output logic                                           alloc_ready,
  output logic [ALLOC_WIDTH*BANK_BITS-1:0]               alloc_bank,
  output logic [ALLOC_WIDTH*SLOT_BITS-1:0]               alloc_slot,
  output logic [NUM_BANKS*SLOTS_PER_BANK-1:0]            bank_alloc_valid,
  output logic [NUM_BANKS*SLOTS_PER_BANK*IDX_BITS-1:0]   bank_alloc_src,
  input  logic [NUM_BANKS*REL_BITS-1:0]                  bank_release_cnt,
  input  logic                                           flush,
  output logic [NUM_BANKS*CRED_BITS-1:0]                 bank_credit,
  output logic                                           credit_err,
  output logic [31:0]                                    stall_count
);

  localparam int unsigned SUM_BITS = CRED_BITS + 1;
  localparam logic signed [SUM_BITS-1:0] ENTRIES_S = SUM_BITS'(BANK_ENTRIES);

  logic [CRED_BITS-1:0]       r_credit [NUM_BANKS];
  logic [BANK_BITS-1:0]       r_rr_ptr;
  logic                       r_credit_err;
  logic [31:0]                r_stall_count;

  logic [BANK_BITS-1:0]       w_req_bank [ALLOC_WIDTH];
  logic [SLOT_BITS-1:0]       w_req_slot [ALLOC_WIDTH];
  logic [ALLOC_WIDTH-1:0]     w_req_placed;
  logic                       w_ready;
  logic [REL_BITS-1:0]        w_alloc_cnt [NUM_BANKS];
  logic signed [SUM_BITS-1:0] w_sum [NUM_BANKS];
  logic [CRED_BITS-1:0]       w_credit_nxt [NUM_BANKS];
  logic                       w_cred_viol;

  // Place the r-th valid request into the visited bank whose cumulative
  // capacity window [base, base+cap) contains r; cap = min(slots, credit).
  always_comb begin
    int unsigned rank;
    int unsigned base;
    int unsigned cap;
    int unsigned b;
    logic        found;
    rank         = 0;
    base         = 0;
    cap          = 0;
    b            = 0;
    found        = 1'b0;
    w_req_placed = '0;
    for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
      w_req_bank[i] = '0;
      w_req_slot[i] = '0;
    end
    for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
      if (alloc_req[i]) begin
        base  = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
          b   = (32'(r_rr_ptr) + k) % NUM_BANKS;
          cap = (32'(r_credit[b]) < SLOTS_PER_BANK) ? 32'(r_credit[b]) : SLOTS_PER_BANK;
          if (!found && (rank >= base) && (rank < base + cap)) begin
            w_req_bank[i]   = BANK_BITS'(b);
            w_req_slot[i]   = SLOT_BITS'(rank - base);
            w_req_placed[i] = 1'b1;
            found           = 1'b1;
          end
          base = base + cap;
        end
        rank = rank + 1;
      end
    end
  end

  // Ready only when every valid request found a slot; forced low in reset.
  assign w_ready     = rst_n & ~flush & (&(~alloc_req | w_req_placed));
  assign alloc_ready = w_ready;

  // Steering outputs, all zero unless the group fires.
  always_comb begin
    alloc_bank       = '0;
    alloc_slot       = '0;
    bank_alloc_valid = '0;
    bank_alloc_src   = '0;
    if (w_ready) begin
      for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
        if (alloc_req[i]) begin
          alloc_bank[i*BANK_BITS +: BANK_BITS] = w_req_bank[i];
          alloc_slot[i*SLOT_BITS +: SLOT_BITS] = w_req_slot[i];
          bank_alloc_valid[32'(w_req_bank[i])*SLOTS_PER_BANK + 32'(w_req_slot[i])] = 1'b1;
          bank_alloc_src[(32'(w_req_bank[i])*SLOTS_PER_BANK + 32'(w_req_slot[i]))*IDX_BITS +: IDX_BITS] =
            IDX_BITS'(i);
        end
      end
    end
  end

  // Fired slots per bank.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      w_alloc_cnt[b] = '0;
      for (int unsigned s = 0; s < SLOTS_PER_BANK; s++) begin
        w_alloc_cnt[b] = w_alloc_cnt[b] + REL_BITS'(bank_alloc_valid[b*SLOTS_PER_BANK + s]);
      end
    end
  end

  // Net credit update with clamping; any clamp flags a credit violation.
  always_comb begin
    w_cred_viol = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      w_sum[b] = $signed({1'b0, r_credit[b]})
               - $signed(SUM_BITS'(w_alloc_cnt[b]))
               + $signed(SUM_BITS'(bank_release_cnt[b*REL_BITS +: REL_BITS]));
      w_credit_nxt[b] = CRED_BITS'($unsigned(w_sum[b]));
      if (w_sum[b][SUM_BITS-1]) begin
        w_credit_nxt[b] = '0;
        w_cred_viol     = 1'b1;
      end else if (w_sum[b] > ENTRIES_S) begin
        w_credit_nxt[b] = CRED_BITS'(BANK_ENTRIES);
        w_cred_viol     = 1'b1;
      end
    end
  end

  // State: flush restores credits and pointer but leaves error/stall intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        r_credit[b] <= CRED_BITS'(BANK_ENTRIES);
      end
      r_rr_ptr      <= '0;
      r_credit_err  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (flush) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          r_credit[b] <= CRED_BITS'(BANK_ENTRIES);
        end
        r_rr_ptr <= '0;
      end else begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          r_credit[b] <= w_credit_nxt[b];
        end
        if (w_ready && (|alloc_req)) begin
          r_rr_ptr <= (r_rr_ptr == BANK_BITS'(NUM_BANKS - 1)) ? '0 : r_rr_ptr + BANK_BITS'(1);
        end
        if (w_cred_viol) begin
          r_credit_err <= 1'b1;
        end
        if ((|alloc_req) && !w_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
          r_stall_count <= r_stall_count + 32'd1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_credit[b*CRED_BITS +: CRED_BITS] = r_credit[b];
    end
  end

  assign credit_err  = r_credit_err;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_superh16_sched_alloc_ctrl.sv
// Scoreboard bench for superh16_sched_alloc_ctrl: directed vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_superh16_sched_alloc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [11:0] alloc_req;
  logic        alloc_ready;
  logic [23:0] alloc_bank;
  logic [23:0] alloc_slot;
  logic [11:0] bank_alloc_valid;
  logic [47:0] bank_alloc_src;
  logic [8:0]  bank_release_cnt;
  logic        flush;
  logic [20:0] bank_credit;
  logic        credit_err;
  logic [31:0] stall_count;

  superh16_sched_alloc_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_req        (alloc_req),
    .alloc_ready      (alloc_ready),
    .alloc_bank       (alloc_bank),
    .alloc_slot       (alloc_slot),
    .bank_alloc_valid (bank_alloc_valid),
    .bank_alloc_src   (bank_alloc_src),
    .bank_release_cnt (bank_release_cnt),
    .flush            (flush),
    .bank_credit      (bank_credit),
    .credit_err       (credit_err),
    .stall_count      (stall_count)
  );

  typedef struct {
    string       name;
    logic        rdy;
    logic [11:0] vld;
    logic [47:0] src;
    logic [23:0] bnk;
    logic [23:0] slt;
    logic [20:0] cred;
    logic        err;
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, want);
    end
  endtask

  task automatic ex_begin(input string n, input logic r, input int c0, input int c1, input int c2,
                          input logic er, input int st);
    e.name  = n;
    e.rdy   = r;
    e.vld   = '0;
    e.src   = '0;
    e.bnk   = '0;
    e.slt   = '0;
    e.cred  = {7'(c2), 7'(c1), 7'(c0)};
    e.err   = er;
    e.stall = 32'(st);
  endtask

  // Request i fires into (bank b, slot s).
  task automatic ex_map(input int i, input int b, input int s);
    e.bnk[i*2 +: 2]         = 2'(b);
    e.slt[i*2 +: 2]         = 2'(s);
    e.vld[b*4 + s]          = 1'b1;
    e.src[(b*4 + s)*4 +: 4] = 4'(i);
  endtask

  task automatic ex_full_rr0;
    for (int i = 0; i < 12; i++) ex_map(i, i / 4, i % 4);
  endtask

  task automatic ex_push;
    q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [11:0] req, input int r0, input int r1,
                       input int r2, input logic fl);
    @(posedge clk);
    #1;
    rst_n            = rst;
    alloc_req        = req;
    bank_release_cnt = {3'(r2), 3'(r1), 3'(r0)};
    flush            = fl;
  endtask

  // Monitor: outputs are settled at the falling edge.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk(x.name, "ready",  64'(alloc_ready),      64'(x.rdy));
      chk(x.name, "valid",  64'(bank_alloc_valid), 64'(x.vld));
      chk(x.name, "src",    64'(bank_alloc_src),   64'(x.src));
      chk(x.name, "bank",   64'(alloc_bank),       64'(x.bnk));
      chk(x.name, "slot",   64'(alloc_slot),       64'(x.slt));
      chk(x.name, "credit", 64'(bank_credit),      64'(x.cred));
      chk(x.name, "err",    64'(credit_err),       64'(x.err));
      chk(x.name, "stall",  64'(stall_count),      64'(x.stall));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    alloc_req        = '0;
    bank_release_cnt = '0;
    flush            = 1'b0;

    drive(0, 12'hFFF, 0, 0, 0, 0);
    ex_begin("in_reset", 0, 64, 64, 64, 0, 0); ex_push();

    drive(1, 12'hFFF, 0, 0, 0, 0);
    ex_begin("full_rr0", 1, 64, 64, 64, 0, 0); ex_full_rr0(); ex_push();

    drive(1, 12'h01F, 0, 0, 0, 0);
    ex_begin("five_rr1", 1, 60, 60, 60, 0, 0);
    for (int i = 0; i < 4; i++) ex_map(i, 1, i);
    ex_map(4, 2, 0);
    ex_push();

    drive(1, 12'hFFF, 4, 0, 0, 1);
    ex_begin("flush_a", 0, 60, 56, 59, 0, 0); ex_push();

    drive(1, 12'h222, 0, 0, 0, 0);
    ex_begin("sparse", 1, 64, 64, 64, 0, 0);
    ex_map(1, 0, 0); ex_map(5, 0, 1); ex_map(9, 0, 2);
    ex_push();

    drive(1, 12'h000, 0, 0, 0, 1);
    ex_begin("flush_b", 0, 61, 64, 64, 0, 0); ex_push();

    // Drain bank0 to 2 while banks 1/2 are replenished; 18 fires keep rr at 0.
    for (int j = 0; j < 18; j++) begin
      drive(1, 12'hFFF, (j < 2) ? 4 : ((j == 2) ? 2 : 0), 4, 4, 0);
    end

    drive(1, 12'hFFF, 0, 0, 0, 0);
    ex_begin("stall_a", 0, 2, 64, 64, 0, 0); ex_push();

    drive(1, 12'hFFF, 2, 0, 0, 0);
    ex_begin("stall_b", 0, 2, 64, 64, 0, 1); ex_push();

    drive(1, 12'hFFF, 0, 0, 0, 0);
    ex_begin("unstall", 1, 4, 64, 64, 0, 2); ex_full_rr0(); ex_push();

    drive(1, 12'h000, 0, 0, 0, 1);
    ex_begin("flush_c", 0, 0, 60, 60, 0, 2); ex_push();

    drive(1, 12'h00F, 0, 0, 0, 0);
    ex_begin("four_rr0", 1, 64, 64, 64, 0, 2);
    for (int i = 0; i < 4; i++) ex_map(i, 0, i);
    ex_push();

    drive(1, 12'hFFF, 4, 4, 4, 0);
    ex_begin("net_rr1", 1, 60, 64, 64, 0, 2);
    for (int i = 0; i < 4; i++) begin
      ex_map(i, 1, i); ex_map(i + 4, 2, i); ex_map(i + 8, 0, i);
    end
    ex_push();

    drive(1, 12'h000, 0, 1, 0, 0);
    ex_begin("empty_ovf", 1, 60, 64, 64, 0, 2); ex_push();

    drive(1, 12'h000, 0, 0, 0, 0);
    ex_begin("err_set", 1, 60, 64, 64, 1, 2); ex_push();

    drive(1, 12'hFFF, 4, 4, 4, 1);
    ex_begin("flush_d", 0, 60, 64, 64, 1, 2); ex_push();

    drive(1, 12'h00F, 0, 0, 0, 0);
    ex_begin("post_flush", 1, 64, 64, 64, 1, 2);
    for (int i = 0; i < 4; i++) ex_map(i, 0, i);
    ex_push();

    drive(1, 12'h0F0, 0, 0, 0, 0);
    ex_begin("hi_rr1", 1, 60, 64, 64, 1, 2);
    for (int i = 0; i < 4; i++) ex_map(i + 4, 1, i);
    ex_push();

    drive(1, 12'h1FF, 0, 0, 0, 0);
    ex_begin("nine_rr2", 1, 60, 60, 64, 1, 2);
    for (int i = 0; i < 4; i++) begin
      ex_map(i, 2, i); ex_map(i + 4, 0, i);
    end
    ex_map(8, 1, 0);
    ex_push();

    drive(0, 12'hFFF, 0, 0, 0, 0);
    ex_begin("async_rst", 0, 64, 64, 64, 0, 0); ex_push();

    drive(1, 12'hFFF, 0, 0, 0, 0);
    ex_begin("after_rst", 1, 64, 64, 64, 0, 0); ex_full_rr0(); ex_push();

    drive(1, 12'h000, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("end", "queue_left", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
